fp_normalize_pack: RTL and testbench
====================================

Name: fp_normalize_pack

Overview:
- Back end of the floating-point adder: takes the aligned-and-added mantissa sum and the common exponent, then renormalises, detects special cases and packs an IEEE-754 single.
- Upstream, the compare/shift stage supplies an exponent already pre-incremented by one and 24-bit mantissas with the hidden bit.
- This block undoes that: a one-bit right correction on carry, then iterative left shift with exponent decrement, one bit per cycle.
- Valid/ready handshake on both sides.

Parameters:
- MANT_W, 24, mantissa width including hidden bit; the sum input is MANT_W+1 bits.
- EXP_W, 8, exponent width.
- EXP_MAX, 255, all-ones exponent (infinity).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept; high only in IDLE.
- sum_sign  in  1  sign of the sum.
- sum_exp  in  8  common exponent, already +1 from upstream.
- sum_mant  in  25  magnitude sum: bit24 = carry, bit23 = hidden position.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  32  packed {sign, exp[7:0], frac[22:0]}.
- out_zero  out  1  result is exactly zero.
- out_ovf  out  1  result saturated to infinity.
- out_denorm  out  1  result is denormal.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, in_ready=1, out_valid=0, result=0, all flags=0. Internal mant/exp/sign registers cleared. Reset mid-operation discards the operation; no output is produced.
- States are IDLE, NORM and DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch inputs and go to NORM. The load rule:
  - sum_exp==0 (upstream wrap of 255): force overflow.
  - else if sum_mant[24]: mant=sum_mant[24:1] (truncate bit0), exp=sum_exp.
  - else: mant=sum_mant[23:0], exp=sum_exp-1.
- NORM: evaluated once per cycle, in priority order:
  1. forced overflow or exp>=EXP_MAX → result={sign,8'hFF,23'h0}, out_ovf=1.
  2. mant==0 → result=32'h0, sign forced 0, out_zero=1.
  3. mant[23]==1 → result={sign,exp,mant[22:0]}.
  4. exp==1 (mant[23]=0) → result={sign,8'h00,mant[22:0]}, out_denorm=1.
  5. else mant<<=1, exp-=1, stay in NORM.
  - Cases 1–4 register result/flags and go to DONE.
- DONE: out_valid=1; result and flags held stable until out_ready. On out_ready, go to IDLE (out_valid=0 next cycle). A new input cannot be accepted in the same cycle as the handoff.
- Latency: accept edge → out_valid after 2 cycles minimum, 2+k cycles for k left shifts, maximum 25. Throughput is one result per latency+1 cycles.
- Rounding: truncation only; no sticky/guard bits.
- Arithmetic: exponent arithmetic is 9-bit internally so sum_exp-1 and comparisons never wrap. mant is MANT_W bits.
- out_valid must never drop without out_ready.
- in_valid while not ready is ignored (upstream must hold).

Decomposition:
- Shared package fp_adder_pkg holds:
  - MANT_W, EXP_W, EXP_MAX, BIAS=127.
  - state enum {IDLE, NORM, DONE}.
  - constants POS_INF=32'h7F800000 and ZERO=32'h0.
  - a pack(sign,exp,frac) function.
- No sub-module needed; the one-bit-per-cycle shifter lives inline. A future parallel leading-zero counter would be a separate fp_lzc module.

Test Plan:
- 1.0+1.0: sum_exp=128, sum_mant=25'h1000000, sign=0 → result=32'h40000000, no flags, out_valid 2 cycles after accept.
- 1.5-1.0: sum_exp=128, sum_mant=25'h0400000 → one shift; result=32'h3F000000, out_valid 3 cycles after accept.
- Exact cancellation: sum_exp=130, sum_mant=0, sign=1 → result=32'h00000000, out_zero=1.
- Overflow: sum_exp=255, sum_mant=25'h1000000 → result=32'h7F800000, out_ovf=1. Also sum_exp=0 → same result.
- Denormal: sum_exp=2, sum_mant=25'h0000001 → result=32'h00000001, out_denorm=1.
- Handshake/reset:
  - Hold out_ready=0 for 5 cycles in DONE → result is stable and in_ready=0 throughout.
  - Assert rst_n=0 during a 20-shift NORM → next cycle IDLE, out_valid=0, in_ready=1, no stale result emitted.

Source files
------------

// File: rtl/fp_adder_pkg.sv
// Shared types and constants for the floating-point adder pipeline.
// Holds IEEE-754 single-precision field widths, the normaliser state type and a pack helper.
package fp_adder_pkg;

  localparam int MANT_W  = 24;
  localparam int EXP_W   = 8;
  localparam int EXP_MAX = 255;
  localparam int BIAS    = 127;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] ZERO    = 32'h0000_0000;

  function automatic logic [31:0] pack(
    input logic              sign,
    input logic [EXP_W-1:0]  exp,
    input logic [MANT_W-2:0] frac
  );
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fp_normalize_pack.sv
// Adder back end: renormalises the aligned mantissa sum one bit per cycle,
// detects zero/overflow/denormal outcomes and packs an IEEE-754 single.
module fp_normalize_pack
  import fp_adder_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sum_sign,
  input  logic [EXP_W-1:0]    sum_exp,
  input  logic [MANT_W:0]     sum_mant,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         result,
  output logic                out_zero,
  output logic                out_ovf,
  output logic                out_denorm
);

  // One extra exponent bit so the upstream +1 correction and limit checks never wrap.
  localparam logic [EXP_W:0] EXP_LIMIT = (EXP_W + 1)'(EXP_MAX);

  state_t            state_q, state_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W:0]    exp_q, exp_d;
  logic              sign_q, sign_d;
  logic              force_ovf_q, force_ovf_d;
  logic [31:0]       result_q, result_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              denorm_q, denorm_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      force_ovf_q <= 1'b0;
      result_q    <= ZERO;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      denorm_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      force_ovf_q <= force_ovf_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      denorm_q    <= denorm_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    force_ovf_d = force_ovf_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    denorm_d    = denorm_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d      = sum_sign;
          // A zero exponent here means upstream wrapped past 255.
          force_ovf_d = (sum_exp == '0);
          if (sum_mant[MANT_W]) begin
            mant_d = sum_mant[MANT_W:1];
            exp_d  = {1'b0, sum_exp};
          end else begin
            mant_d = sum_mant[MANT_W-1:0];
            exp_d  = {1'b0, sum_exp} - (EXP_W + 1)'(1);
          end
          state_d = NORM;
        end
      end

      NORM: begin
        zero_d   = 1'b0;
        ovf_d    = 1'b0;
        denorm_d = 1'b0;
        if (force_ovf_q || (exp_q >= EXP_LIMIT)) begin
          result_d = pack(sign_q, '1, '0);
          ovf_d    = 1'b1;
          state_d  = DONE;
        end else if (mant_q == '0) begin
          result_d = ZERO;
          zero_d   = 1'b1;
          state_d  = DONE;
        end else if (mant_q[MANT_W-1]) begin
          result_d = pack(sign_q, exp_q[EXP_W-1:0], mant_q[MANT_W-2:0]);
          state_d  = DONE;
        end else if (exp_q <= (EXP_W + 1)'(1)) begin
          // Exponent 0 can only arise from a sum_exp of 1 without carry; treat it as denormal too.
          result_d = pack(sign_q, '0, mant_q[MANT_W-2:0]);
          denorm_d = 1'b1;
          state_d  = DONE;
        end else begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - (EXP_W + 1)'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign result     = result_q;
  assign out_zero   = zero_q;
  assign out_ovf    = ovf_q;
  assign out_denorm = denorm_q;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Directed bench for fp_normalize_pack: hand-computed results, flags, latency,
// handshake hold behaviour and mid-operation reset.
module tb_fp_normalize_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sum_sign = 1'b0;
  logic [7:0]  sum_exp = 8'd0;
  logic [24:0] sum_mant = 25'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        out_zero;
  logic        out_ovf;
  logic        out_denorm;

  int n_tests = 0;
  int n_fail  = 0;

  fp_normalize_pack dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum_sign   (sum_sign),
    .sum_exp    (sum_exp),
    .sum_mant   (sum_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .out_denorm (out_denorm)
  );

  always #5 clk = ~clk;

  // Drives one operand set from IDLE and waits (bounded) for out_valid.
  // lat counts cycles from the accept cycle (0) to the first out_valid cycle; -1 on timeout.
  task automatic do_op(input logic s, input logic [7:0] e, input logic [24:0] m,
                       output logic [31:0] res, output logic [2:0] flags, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    sum_sign = s;
    sum_exp  = e;
    sum_mant = m;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    res   = result;
    flags = {out_zero, out_ovf, out_denorm};
  endtask

  task automatic ack();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    n_tests++;
    if (result !== 32'h0 || {out_zero, out_ovf, out_denorm} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_out got result=%h flags=%b want 00000000/000", result,
               {out_zero, out_ovf, out_denorm});
    end
    $display("[TB] reset: in_ready=%b out_valid=%b result=%h", in_ready, out_valid, result);
  endtask

  task automatic test_normal();
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    // 1.0 + 1.0: carry path, no shift.
    do_op(1'b0, 8'd128, 25'h1000000, r, f, lat);
    n_tests++;
    if (r !== 32'h40000000 || f !== 3'b000) begin
      n_fail++;
      $display("FAIL add_1p1 got %h/%b want 40000000/000", r, f);
    end
    n_tests++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL add_1p1_lat got %0d want 2", lat);
    end
    $display("[TB] 1.0+1.0 -> %h flags=%b lat=%0d", r, f, lat);
    ack();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL handoff got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end

    // 1.5 - 1.0: one left shift.
    do_op(1'b0, 8'd128, 25'h0400000, r, f, lat);
    n_tests++;
    if (r !== 32'h3F000000 || f !== 3'b000) begin
      n_fail++;
      $display("FAIL sub_1p5 got %h/%b want 3F000000/000", r, f);
    end
    n_tests++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL sub_1p5_lat got %0d want 3", lat);
    end
    $display("[TB] 1.5-1.0 -> %h flags=%b lat=%0d", r, f, lat);
    ack();

    // 20 left shifts: mant bit3 -> bit23, exp 99 -> 79.
    do_op(1'b0, 8'd100, 25'h0000008, r, f, lat);
    n_tests++;
    if (r !== 32'h27800000 || f !== 3'b000 || lat !== 22) begin
      n_fail++;
      $display("FAIL shift20 got %h/%b lat=%0d want 27800000/000 lat=22", r, f, lat);
    end
    $display("[TB] 20-shift -> %h flags=%b lat=%0d", r, f, lat);
    ack();
  endtask

  task automatic test_specials();
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    do_op(1'b1, 8'd130, 25'h0, r, f, lat);
    n_tests++;
    if (r !== 32'h00000000 || f !== 3'b100) begin
      n_fail++;
      $display("FAIL cancel got %h/%b want 00000000/100", r, f);
    end
    $display("[TB] cancel -> %h flags=%b lat=%0d", r, f, lat);
    ack();

    do_op(1'b0, 8'd255, 25'h1000000, r, f, lat);
    n_tests++;
    if (r !== 32'h7F800000 || f !== 3'b010) begin
      n_fail++;
      $display("FAIL ovf_255 got %h/%b want 7F800000/010", r, f);
    end
    $display("[TB] ovf exp255 -> %h flags=%b lat=%0d", r, f, lat);
    ack();

    do_op(1'b0, 8'd0, 25'h0800000, r, f, lat);
    n_tests++;
    if (r !== 32'h7F800000 || f !== 3'b010) begin
      n_fail++;
      $display("FAIL ovf_wrap got %h/%b want 7F800000/010", r, f);
    end
    $display("[TB] ovf exp0 -> %h flags=%b lat=%0d", r, f, lat);
    ack();

    do_op(1'b0, 8'd2, 25'h0000001, r, f, lat);
    n_tests++;
    if (r !== 32'h00000001 || f !== 3'b001) begin
      n_fail++;
      $display("FAIL denorm got %h/%b want 00000001/001", r, f);
    end
    n_tests++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL denorm_lat got %0d want 2", lat);
    end
    $display("[TB] denorm -> %h flags=%b lat=%0d", r, f, lat);
    ack();
  endtask

  // Holds DONE for 5 cycles while new operands are offered, then checks they are
  // taken only after the handoff cycle.
  task automatic test_back_to_back();
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    do_op(1'b1, 8'd128, 25'h1000000, r, f, lat);
    n_tests++;
    if (r !== 32'hC0000000) begin
      n_fail++;
      $display("FAIL neg_add got %h want C0000000", r);
    end
    in_valid = 1'b1;
    sum_sign = 1'b0;
    sum_exp  = 8'd255;
    sum_mant = 25'h1000000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'hC0000000) begin
        n_fail++;
        $display("FAIL hold[%0d] got ov=%b ir=%b res=%h want 1/0/C0000000", i, out_valid,
                 in_ready, result);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL no_same_cycle got ov=%b ir=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    n_tests++;
    if (result !== 32'h7F800000 || out_ovf !== 1'b1 || lat !== 2) begin
      n_fail++;
      $display("FAIL b2b got %h ovf=%b lat=%0d want 7F800000 1 2", result, out_ovf, lat);
    end
    $display("[TB] back-to-back -> %h ovf=%b lat=%0d", result, out_ovf, lat);
    ack();
  endtask

  task automatic test_reset_mid_op();
    bit seen = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    sum_sign = 1'b0;
    sum_exp  = 8'd100;
    sum_mant = 25'h0000008;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_norm got ov=%b ir=%b want 0/0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 ||
        {out_zero, out_ovf, out_denorm} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset got ir=%b ov=%b res=%h flags=%b want 1/0/00000000/000",
               in_ready, out_valid, result, {out_zero, out_ovf, out_denorm});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_out got out_valid seen=%b want 0", seen);
    end
    $display("[TB] reset mid-op: stale output seen=%b", seen);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_normal();
    test_specials();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
